inv_sub_shift_rows: RTL and testbench

Iterative AES inverse-cipher stage. It applies InvShiftRows followed by InvSubBytes to one 128-bit state per transaction. The state is accepted over a valid/ready input channel and processed BYTES_PER_CYCLE bytes per clock through inverse S-box lookups. The result is presented on a valid/ready output channel. It sits in the decryption round datapath, between AddRoundKey/InvMixColumns and the next round.

---
 rtl/inv_sub_shift_rows_pkg.sv | 31 +++
 rtl/inv_sub_shift_rows_inv_sbox.sv | 34 +++
 rtl/inv_sub_shift_rows.sv | 131 +++++++++++++
 tb/tb_inv_sub_shift_rows.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_sub_shift_rows_pkg.sv
// Shared AES definitions for the inverse ShiftRows/SubBytes stage.
//   BLOCK_W / BYTE_W / NB : state geometry (128-bit state, 8-bit bytes, 4 columns)
//   state_t               : control FSM states
//   inv_shift_src(i)      : source byte index that InvShiftRows moves into output byte i
// Byte k of a state lives at [127-8k -: 8] and sits at row k%4, column k/4.
package inv_sub_shift_rows_pkg;

  localparam int BLOCK_W = 128;
  localparam int BYTE_W  = 8;
  localparam int NB      = 4;
  localparam int NBYTES  = BLOCK_W / BYTE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Output (r,c) takes input (r, (c-r) mod 4). Index i = {c, r}, so the
  // column subtraction is plain 2-bit wraparound arithmetic.
  function automatic logic [3:0] inv_shift_src(input logic [3:0] i);
    logic [1:0] row;
    logic [1:0] col;
    logic [1:0] src_col;
    row     = i[1:0];
    col     = i[3:2];
    src_col = col - row;
    return {src_col, row};
  endfunction

endpackage

// File: rtl/inv_sub_shift_rows_inv_sbox.sv
// AES inverse S-box: purely combinational 256-entry lookup.
//   in_byte  : byte to substitute
//   out_byte : InvSbox(in_byte)
module inv_sbox
  import inv_sub_shift_rows_pkg::*;
(
  input  logic [BYTE_W-1:0] in_byte,
  output logic [BYTE_W-1:0] out_byte
);

  // Entry x sits at bits [(255-x)*8 +: 8]; one 128-bit row per 16 entries.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // (255 - x) * 8 == {~x, 3'b000}
  assign out_byte = INV_SBOX[{~in_byte, 3'b000} +: BYTE_W];

endmodule

// File: rtl/inv_sub_shift_rows.sv
// Iterative InvShiftRows + InvSubBytes over one 128-bit AES state.
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    : input handshake, in_state captured on the accepting edge
//   in_state             : state to transform, byte 0 at [127:120]
//   out_valid/out_ready  : output handshake, out_state held until accepted
//   out_state            : InvSubBytes(InvShiftRows(in_state))
//   busy                 : a transaction is being processed or awaiting pickup
// Handshake rule: a transfer happens on the rising edge where valid && ready;
// valid, once raised, holds with its data until that edge, and ready may
// depend combinationally on the other side's ready (in_ready uses out_ready
// so a result can be handed off and the next state taken in the same cycle).
module inv_sub_shift_rows
  import inv_sub_shift_rows_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_state,
  output logic               busy
);

  localparam int         BPC      = BYTES_PER_CYCLE;
  localparam logic [3:0] STEP     = 4'(BPC);
  localparam logic [3:0] LAST_CNT = 4'(NBYTES - BPC);

  if (BPC != 1 && BPC != 2 && BPC != 4) begin : g_bpc_check
    $error("BYTES_PER_CYCLE must be 1, 2 or 4");
  end

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               last_q, last_d;
  logic [BLOCK_W-1:0] cap_q, out_q, out_d;
  logic               load, write;

  logic [3:0]        idx    [BPC];
  logic [3:0]        src    [BPC];
  logic [BYTE_W-1:0] sb_in  [BPC];
  logic [BYTE_W-1:0] sb_out [BPC];

  // One lookup lane per byte handled this cycle: lane g produces output byte
  // cnt+g from the captured byte that InvShiftRows moves there.
  for (genvar g = 0; g < BPC; g++) begin : g_lane
    assign idx[g]   = cnt_q + 4'(g);
    assign src[g]   = inv_shift_src(idx[g]);
    assign sb_in[g] = cap_q[{~src[g], 3'b000} +: BYTE_W];
    inv_sbox u_inv_sbox (
      .in_byte  (sb_in[g]),
      .out_byte (sb_out[g])
    );
  end

  assign in_ready  = rst_n && ((state_q == IDLE) || (state_q == DONE && out_ready));
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY) || (state_q == DONE);
  assign out_state = out_q;

  // last_q marks that the final group has been written; BUSY spends one more
  // cycle before presenting, giving 16/BPC+1 cycles per state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    load    = 1'b0;
    write   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) load = 1'b1;
      end
      BUSY: begin
        if (last_q) begin
          state_d = DONE;
        end else begin
          write = 1'b1;
          if (cnt_q == LAST_CNT) last_d = 1'b1;
          else                   cnt_d  = cnt_q + STEP;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          if (in_valid && in_ready) load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = BUSY;
      cnt_d   = '0;
      last_d  = 1'b0;
    end
  end

  always_comb begin
    out_d = out_q;
    if (write) begin
      for (int j = 0; j < BPC; j++) begin
        out_d[{~idx[j], 3'b000} +: BYTE_W] = sb_out[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
      out_q <= '0;
    end else begin
      if (load) cap_q <= in_state;
      out_q <= out_d;
    end
  end

endmodule

// File: tb/tb_inv_sub_shift_rows.sv
// Bench for inv_sub_shift_rows: three instances (1, 2 and 4 bytes per cycle)
// against a reference built from the AES definitions (GF(2^8) inverse plus
// affine map, inverted into a lookup; row/column rotation for InvShiftRows).
module tb_inv_sub_shift_rows;

  localparam int BPC_TAB [3] = '{1, 2, 4};

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];
  logic         busy      [3];

  inv_sub_shift_rows #(.BYTES_PER_CYCLE(1)) u_bpc1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_state(out_state[0]), .busy(busy[0]));
  inv_sub_shift_rows #(.BYTES_PER_CYCLE(2)) u_bpc2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_state(out_state[1]), .busy(busy[1]));
  inv_sub_shift_rows #(.BYTES_PER_CYCLE(4)) u_bpc4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_state(in_state[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_state(out_state[2]), .busy(busy[2]));

  // ---------------- reference model ----------------
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_model(input logic [127:0] s);
    logic [127:0] o;
    int sc;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        sc = (c - r + 4) % 4;
        o[127 - 8*(4*c + r) -: 8] = inv_tab[s[127 - 8*(4*sc + r) -: 8]];
      end
    return o;
  endfunction

  // ---------------- scoreboard / checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_out_valid(input int d, output int lat);
    lat = 0;
    while (!out_valid[d] && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Single transaction with out_ready held high: checks latency and result.
  task automatic run_txn(input int d, input logic [127:0] s, input logic [127:0] exp,
                         input string tag);
    int lat;
    @(negedge clk);
    in_valid[d] = 1'b1; in_state[d] = s; out_ready[d] = 1'b1;
    #1 check({tag, "_in_ready"}, 128'(in_ready[d]), 128'(1));
    @(negedge clk);
    in_valid[d] = 1'b0;
    check({tag, "_busy"}, 128'(busy[d]), 128'(1));
    wait_out_valid(d, lat);
    check({tag, "_latency"}, 128'(lat), 128'(16 / BPC_TAB[d] + 1));
    check({tag, "_data"}, out_state[d], exp);
    @(negedge clk);
    check({tag, "_valid_drop"}, 128'(out_valid[d]), 128'(0));
  endtask

  task automatic random_run(input int d, input int n);
    logic [127:0] exp_q [$];
    logic [127:0] cur;
    int  sent, recv, gap, cycles;
    bit  have;
    sent = 0; recv = 0; gap = 0; cycles = 0; have = 1'b0; cur = '0;
    while (recv < n && cycles < n * 40) begin
      @(negedge clk);
      cycles++;
      if (!have && sent < n) begin
        if (gap == 0) begin
          cur  = {$urandom, $urandom, $urandom, $urandom};
          have = 1'b1;
        end else begin
          gap--;
        end
      end
      in_valid[d]  = have;
      in_state[d]  = cur;
      out_ready[d] = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid[d] && in_ready[d]) begin
        exp_q.push_back(ref_model(cur));
        have = 1'b0;
        sent++;
        gap = $urandom_range(0, 2);
      end
      if (out_valid[d] && out_ready[d]) begin
        if (exp_q.size() == 0) begin
          check($sformatf("rand_bpc%0d_extra_output", BPC_TAB[d]), 128'(out_valid[d]), 128'(0));
        end else begin
          check($sformatf("rand_bpc%0d_data", BPC_TAB[d]), out_state[d], exp_q.pop_front());
          recv++;
        end
      end
    end
    @(negedge clk);
    in_valid[d] = 1'b0; out_ready[d] = 1'b0;
    check($sformatf("rand_bpc%0d_sent", BPC_TAB[d]), 128'(sent), 128'(n));
    check($sformatf("rand_bpc%0d_received", BPC_TAB[d]), 128'(recv), 128'(n));
    check($sformatf("rand_bpc%0d_leftover", BPC_TAB[d]), 128'(exp_q.size()), 128'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] s, e, s1, s2;
    int lat;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; in_state[d] = '0; out_ready[d] = 1'b0;
    end
    build_tables();

    // Reset / idle
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_in_ready_%0d", d), 128'(in_ready[d]), 128'(0));
      check($sformatf("rst_out_valid_%0d", d), 128'(out_valid[d]), 128'(0));
      check($sformatf("rst_busy_%0d", d), 128'(busy[d]), 128'(0));
      check($sformatf("rst_out_state_%0d", d), out_state[d], 128'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("idle_in_ready_%0d", d), 128'(in_ready[d]), 128'(1));
      check($sformatf("idle_out_valid_%0d", d), 128'(out_valid[d]), 128'(0));
      check($sformatf("idle_busy_%0d", d), 128'(busy[d]), 128'(0));
    end

    // Known-answer vectors
    for (int d = 0; d < 3; d++)
      run_txn(d, {16{8'h63}}, 128'(0), $sformatf("uniform63_bpc%0d", BPC_TAB[d]));
    s = {16{8'h63}};
    s[119:112] = 8'h7c;
    e = '0;
    e[87:80] = 8'h01;
    run_txn(0, s, e, "shift_byte1");
    run_txn(2, s, e, "shift_byte1_bpc4");
    run_txn(0, {16{8'h52}}, {16{8'h48}}, "uniform52");
    run_txn(1, {16{8'h16}}, {16{8'hff}}, "uniform16");

    // Backpressure, with a competing in_valid ignored while BUSY/DONE
    s1 = {$urandom, $urandom, $urandom, $urandom};
    s2 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_valid[0] = 1'b1; in_state[0] = s1; out_ready[0] = 1'b0;
    @(negedge clk);
    in_state[0] = s2;
    #1 check("bp_busy_in_ready", 128'(in_ready[0]), 128'(0));
    wait_out_valid(0, lat);
    check("bp_latency", 128'(lat), 128'(17));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      check("bp_hold_data", out_state[0], ref_model(s1));
      check("bp_hold_valid", 128'(out_valid[0]), 128'(1));
      check("bp_hold_in_ready", 128'(in_ready[0]), 128'(0));
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    #1 check("bp_release_in_ready", 128'(in_ready[0]), 128'(1));
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("bp_next_busy", 128'(busy[0]), 128'(1));
    check("bp_next_valid_drop", 128'(out_valid[0]), 128'(0));
    wait_out_valid(0, lat);
    check("bp_next_latency", 128'(lat), 128'(17));
    check("bp_next_data", out_state[0], ref_model(s2));
    @(negedge clk);
    out_ready[0] = 1'b0;

    // Reset in the middle of BUSY
    @(negedge clk);
    in_valid[0] = 1'b1; in_state[0] = {$urandom, $urandom, $urandom, $urandom}; out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(out_valid[0]), 128'(0));
    check("midrst_busy", 128'(busy[0]), 128'(0));
    check("midrst_out_state", out_state[0], 128'(0));
    check("midrst_in_ready", 128'(in_ready[0]), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_after_valid", 128'(out_valid[0]), 128'(0));
    s = {$urandom, $urandom, $urandom, $urandom};
    run_txn(0, s, ref_model(s), "midrst_next");

    // Randomized traffic on every lane width
    for (int d = 0; d < 3; d++) random_run(d, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
